// File: rtl/requant_pkg.sv
// Shared widths, saturation bounds, configuration record and the
// saturating narrowing helper for the requantization unit.
package requant_pkg;

   localparam int ACC_W   = 32;
   localparam int MULT_W  = 16;
   localparam int SHIFT_W = 5;
   localparam int OUT_W   = 8;
   localparam int PROD_W  = ACC_W + MULT_W + 1;

   // Saturation bounds, sign-extended to the full datapath width
   localparam logic signed [PROD_W-1:0] OUT_MAX =
      {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] OUT_MIN =
      {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef struct packed {
      logic        [MULT_W-1:0]  mult;
      logic        [SHIFT_W-1:0] shift;
      logic signed [OUT_W-1:0]   zp;
   } cfg_t;

   // Identity requantization: M = 1, S = 0, ZP = 0
   localparam cfg_t CFG_RESET = '{
      mult:  {{(MULT_W-1){1'b0}}, 1'b1},
      shift: {SHIFT_W{1'b0}},
      zp:    {OUT_W{1'b0}}
   };

   // Clamp a wide signed value into the signed OUT_W range
   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PROD_W-1:0] t);
      logic signed [OUT_W-1:0] r;
      if (t > OUT_MAX) begin
         r = OUT_MAX[OUT_W-1:0];
      end else if (t < OUT_MIN) begin
         r = OUT_MIN[OUT_W-1:0];
      end else begin
         r = t[OUT_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: multiply, round-shift, add zero point and
// saturate, split across three registered stages that advance together.
module requant_lane
   import requant_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    adv,
   input  logic signed [ACC_W-1:0] acc,
   input  cfg_t                    cfg,
   output logic signed [OUT_W-1:0] q
);

   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] prod_r;
   logic signed [PROD_W-1:0] half;
   logic signed [PROD_W-1:0] biased;
   logic signed [PROD_W-1:0] rounded;
   logic signed [PROD_W-1:0] rnd_r;
   logic signed [PROD_W-1:0] total;

   // Stage-1 product: M is unsigned, so it is widened with a zero sign bit
   always_comb begin
      prod = PROD_W'(acc) * PROD_W'($signed({1'b0, cfg.mult}));
   end

   // Stage-2 rounding: add half an LSB of the result, then arithmetic shift
   always_comb begin
      half    = {PROD_W{1'b0}};
      biased  = prod_r;
      rounded = prod_r;
      if (cfg.shift == {SHIFT_W{1'b0}}) begin
         rounded = prod_r;
      end else begin
         half    = {{(PROD_W-1){1'b0}}, 1'b1} <<< (cfg.shift - {{(SHIFT_W-1){1'b0}}, 1'b1});
         biased  = prod_r + half;
         rounded = biased >>> cfg.shift;
      end
   end

   // Stage-3 zero-point offset ahead of saturation
   always_comb begin
      total = rnd_r + PROD_W'(cfg.zp);
   end

   // Pipeline registers: all stages move only when the unit is not stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_r <= {PROD_W{1'b0}};
         rnd_r  <= {PROD_W{1'b0}};
         q      <= {OUT_W{1'b0}};
      end else if (adv) begin
         prod_r <= prod;
         rnd_r  <= rounded;
         q      <= sat_out(total);
      end else begin
         prod_r <= prod_r;
         rnd_r  <= rnd_r;
         q      <= q;
      end
   end

endmodule

// File: rtl/requant_unit.sv
// Four-lane requantizer between the systolic array and the activation unit.
// Holds the stage valid bits, the backpressure logic and the layer config.
module requant_unit
   import requant_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [ACC_W-1:0]   acc1,
   input  logic signed [ACC_W-1:0]   acc2,
   input  logic signed [ACC_W-1:0]   acc3,
   input  logic signed [ACC_W-1:0]   acc4,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [OUT_W-1:0]   q1,
   output logic signed [OUT_W-1:0]   q2,
   output logic signed [OUT_W-1:0]   q3,
   output logic signed [OUT_W-1:0]   q4,
   input  logic                      cfg_we,
   input  logic        [MULT_W-1:0]  cfg_mult,
   input  logic        [SHIFT_W-1:0] cfg_shift,
   input  logic signed [OUT_W-1:0]   cfg_zp,
   output logic                      busy
);

   logic v1;
   logic v2;
   logic v3;
   logic stall;
   logic accept;
   cfg_t cfg;

   assign out_valid = v3;
   assign stall     = v3 & ~out_ready;
   assign in_ready  = ~stall;
   assign accept    = in_valid & in_ready;
   assign busy      = v1 | v2 | v3;

   // Stage valid bits: shift as one unit, bubbles travel with the data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (!stall) begin
         v1 <= accept;
         v2 <= v1;
         v3 <= v2;
      end else begin
         v1 <= v1;
         v2 <= v2;
         v3 <= v3;
      end
   end

   // Layer config: writable only with an empty pipe and no beat entering,
   // so every in-flight beat sees one consistent setting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg <= CFG_RESET;
      end else if (cfg_we && !busy && !accept) begin
         cfg <= '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp};
      end else begin
         cfg <= cfg;
      end
   end

   requant_lane u_lane1 (.clk(clk), .rst(rst), .adv(~stall), .acc(acc1), .cfg(cfg), .q(q1));
   requant_lane u_lane2 (.clk(clk), .rst(rst), .adv(~stall), .acc(acc2), .cfg(cfg), .q(q2));
   requant_lane u_lane3 (.clk(clk), .rst(rst), .adv(~stall), .acc(acc3), .cfg(cfg), .q(q3));
   requant_lane u_lane4 (.clk(clk), .rst(rst), .adv(~stall), .acc(acc4), .cfg(cfg), .q(q4));

endmodule

// File: tb/tb_requant_unit.sv
// Scoreboard bench for requant_unit: directed beats push hand-computed
// results into a queue, an independent monitor pops on each output handshake.
module tb_requant_unit;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [31:0] acc1 = 32'sd0, acc2 = 32'sd0, acc3 = 32'sd0, acc4 = 32'sd0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [7:0]  q1, q2, q3, q4;
   logic               cfg_we = 1'b0;
   logic        [15:0] cfg_mult = 16'd1;
   logic        [4:0]  cfg_shift = 5'd0;
   logic signed [7:0]  cfg_zp = 8'sd0;
   logic               busy;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];

   requant_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .acc1(acc1), .acc2(acc2), .acc3(acc3), .acc4(acc4),
      .out_valid(out_valid), .out_ready(out_ready),
      .q1(q1), .q2(q2), .q3(q3), .q4(q4),
      .cfg_we(cfg_we), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Monitor: on every output handshake, compare against the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", {q1, q2, q3, q4}, 32'hxxxx_xxxx);
            end else begin
               check("beat", {q1, q2, q3, q4}, sb.pop_front());
            end
         end
      end
   end

   task automatic send(input logic signed [31:0] a1, a2, a3, a4,
                       input logic signed [7:0] e1, e2, e3, e4);
      bit done = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      acc1 = a1; acc2 = a2; acc3 = a3; acc4 = a4;
      for (int n = 0; n < 100 && !done; n++) begin
         #2;
         if (in_ready) begin
            sb.push_back({e1, e2, e3, e4});
            done = 1'b1;
         end
         @(posedge clk);
         if (!done) @(negedge clk);
      end
      #1 in_valid = 1'b0;
      if (!done) begin
         check("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int n = 0; n < 100 && !idle; n++) begin
         @(negedge clk);
         #3;
         idle = (!busy && sb.size() == 0);
      end
      if (!idle) begin
         check("drain_timeout", 32'(sb.size()), 32'd0);
      end
   endtask

   task automatic cfg(input logic [15:0] m, input logic [4:0] s, input logic signed [7:0] zp);
      @(negedge clk);
      cfg_we = 1'b1; cfg_mult = m; cfg_shift = s; cfg_zp = zp;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [31:0] held;
      // Reset state
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_q", {q1, q2, q3, q4}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // 1: identity config, latency of exactly three cycles
      send(32'sd100, -32'sd7, 32'sd0, 32'sd127, 8'sd100, -8'sd7, 8'sd0, 8'sd127);
      lat = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         #2;
         lat++;
         if (out_valid) break;
      end
      check("latency", 32'(lat), 32'd3);
      wait_idle();

      // 2: saturation at both rails
      send(32'sd300, -32'sd1000, 32'sh7fff_ffff, 32'sh8000_0000,
           8'sd127, -8'sd128, 8'sd127, -8'sd128);
      wait_idle();

      // 3: rounding half toward +inf, then scaled with zero point
      cfg(16'd1, 5'd1, 8'sd0);
      send(32'sd5, -32'sd5, 32'sd4, -32'sd4, 8'sd3, -8'sd2, 8'sd2, -8'sd2);
      wait_idle();
      cfg(16'd3, 5'd2, 8'sd10);
      send(32'sd7, 32'sd0, -32'sd8, 32'sd1000, 8'sd15, 8'sd10, 8'sd4, 8'sd127);
      wait_idle();
      // maximum shift with negative zero point
      cfg(16'd1, 5'd31, -8'sd5);
      send(32'sh4000_0000, 32'sh3fff_ffff, 32'sh8000_0000, 32'shc000_0000,
           -8'sd4, -8'sd5, -8'sd6, -8'sd5);
      wait_idle();

      // 4: backpressure for four cycles from the first out_valid
      cfg(16'd1, 5'd0, 8'sd0);
      fork
         begin
            send(32'sd1, 32'sd2, 32'sd3, 32'sd4, 8'sd1, 8'sd2, 8'sd3, 8'sd4);
            send(-32'sd1, -32'sd2, -32'sd3, -32'sd4, -8'sd1, -8'sd2, -8'sd3, -8'sd4);
            send(32'sd10, 32'sd20, 32'sd30, 32'sd40, 8'sd10, 8'sd20, 8'sd30, 8'sd40);
            send(32'sd200, -32'sd200, 32'sd5, -32'sd5, 8'sd127, -8'sd128, 8'sd5, -8'sd5);
            send(32'sd0, 32'sd0, 32'sd0, 32'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
            send(-32'sd128, 32'sd127, -32'sd129, 32'sd128, -8'sd128, 8'sd127, -8'sd128, 8'sd127);
         end
         begin
            bit seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
               @(negedge clk);
               seen = out_valid;
            end
            check("bp_first_valid", {31'd0, seen}, 32'd1);
            out_ready = 1'b0;
            held = {q1, q2, q3, q4};
            for (int i = 0; i < 4; i++) begin
               #2;
               check("bp_in_ready", {31'd0, in_ready}, 32'd0);
               check("bp_q_hold", {q1, q2, q3, q4}, held);
               check("bp_busy", {31'd0, busy}, 32'd1);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      wait_idle();

      // 5: config write while busy is dropped
      send(32'sd10, 32'sd0, 32'sd0, 32'sd0, 8'sd10, 8'sd0, 8'sd0, 8'sd0);
      @(negedge clk);
      check("gate_busy", {31'd0, busy}, 32'd1);
      cfg_we = 1'b1; cfg_mult = 16'd2;
      @(negedge clk);
      cfg_we = 1'b0;
      wait_idle();
      send(32'sd50, 32'sd0, 32'sd0, 32'sd0, 8'sd50, 8'sd0, 8'sd0, 8'sd0);
      wait_idle();
      cfg(16'd2, 5'd0, 8'sd0);
      send(32'sd50, -32'sd3, 32'sd0, 32'sd1, 8'sd100, -8'sd6, 8'sd0, 8'sd2);
      wait_idle();
      // write coinciding with an accepted beat is dropped too
      @(negedge clk);
      in_valid = 1'b1; acc1 = 32'sd20; acc2 = 32'sd0; acc3 = 32'sd0; acc4 = 32'sd0;
      cfg_we = 1'b1; cfg_mult = 16'd3;
      #2;
      check("coincide_in_ready", {31'd0, in_ready}, 32'd1);
      sb.push_back({8'sd40, 8'sd0, 8'sd0, 8'sd0});
      @(posedge clk);
      #1 in_valid = 1'b0; cfg_we = 1'b0;
      send(32'sd30, 32'sd0, 32'sd0, 32'sd0, 8'sd60, 8'sd0, 8'sd0, 8'sd0);
      wait_idle();

      // 6: reset with three beats in flight
      cfg(16'd2, 5'd1, 8'sd3);
      send(32'sd1, 32'sd1, 32'sd1, 32'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
      send(32'sd2, 32'sd2, 32'sd2, 32'sd2, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
      send(32'sd3, 32'sd3, 32'sd3, 32'sd3, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
      rst = 1'b1;
      sb.delete();
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_q", {q1, q2, q3, q4}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #2;
         check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
      end
      send(32'sd7, -32'sd3, 32'sd0, 32'sd1, 8'sd7, -8'sd3, 8'sd0, 8'sd1);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
